// File: rtl/fir_sample_scheduler_if.sv
// Stream, result and engine-side signals of the FIR sample scheduler.
// slave is the scheduler's view; master is the surrounding system's view.
interface fir_sample_scheduler_if #(
    parameter int IN_WIDTH  = 16,
    parameter int ACC_WIDTH = 40,
    parameter int CNT_WIDTH = 16
);
    logic                 enable;
    logic                 flush;
    logic [IN_WIDTH-1:0]  s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic [ACC_WIDTH-1:0] m_data;
    logic                 m_valid;
    logic                 m_ready;
    logic [IN_WIDTH-1:0]  fir_data_in;
    logic                 fir_in_valid;
    logic [ACC_WIDTH-1:0] fir_data_out;
    logic                 fir_out_valid;
    logic                 fir_srst_n;
    logic                 timeout_err;
    logic [CNT_WIDTH-1:0] overrun_cnt;

    modport slave (
        input  enable,
        input  flush,
        input  s_data,
        input  s_valid,
        output s_ready,
        output m_data,
        output m_valid,
        input  m_ready,
        output fir_data_in,
        output fir_in_valid,
        input  fir_data_out,
        input  fir_out_valid,
        output fir_srst_n,
        output timeout_err,
        output overrun_cnt
    );

    modport master (
        output enable,
        output flush,
        output s_data,
        output s_valid,
        input  s_ready,
        input  m_data,
        input  m_valid,
        output m_ready,
        input  fir_data_in,
        input  fir_in_valid,
        output fir_data_out,
        output fir_out_valid,
        input  fir_srst_n,
        input  timeout_err,
        input  overrun_cnt
    );
endinterface

// File: rtl/fir_sample_scheduler.sv
// Feeds one buffered sample at a time into a non-stallable FIR engine,
// holds its result for a valid/ready sink and resets the engine if it hangs.
module fir_sample_scheduler #(
    parameter int IN_WIDTH    = 16,
    parameter int ACC_WIDTH   = 40,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 512,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    fir_sample_scheduler_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RECOVER
    } state_t;

    logic [IN_WIDTH-1:0]  mem_q [FIFO_DEPTH];
    logic [PW:0]          wptr_q;
    logic [PW:0]          wptr_d;
    logic [PW:0]          rptr_q;
    logic [PW:0]          rptr_d;
    logic                 full_q;
    logic                 full_d;
    logic                 empty;
    logic                 push;
    logic                 pop;

    state_t               state_q;
    logic [TW-1:0]        timer_q;
    logic                 rec_cnt_q;
    logic                 recover_q;
    logic [IN_WIDTH-1:0]  din_q;
    logic                 inv_q;
    logic [ACC_WIDTH-1:0] mdata_q;
    logic                 mvalid_q;
    logic                 terr_q;
    logic [CNT_WIDTH-1:0] ovr_q;

    assign empty = (wptr_q == rptr_q);
    assign push  = bus.s_valid & ~full_q & ~bus.flush;
    assign pop   = (state_q == IDLE) & bus.enable & ~empty & ~mvalid_q;

    // Flush snaps the read pointer onto the write pointer; a same-cycle
    // pop has already captured its sample, so nothing in flight is lost.
    always_comb begin
        wptr_d = wptr_q + {{PW{1'b0}}, push};
        rptr_d = rptr_q + {{PW{1'b0}}, pop};
        if (bus.flush) begin
            rptr_d = wptr_q;
        end
        full_d = (wptr_d[PW] != rptr_d[PW]) &&
                 (wptr_d[PW-1:0] == rptr_d[PW-1:0]);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[PW-1:0]] <= bus.s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            full_q <= 1'b0;
            ovr_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            full_q <= full_d;
            if (bus.s_valid && full_q && (ovr_q != '1)) begin
                ovr_q <= ovr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            rec_cnt_q <= 1'b0;
            recover_q <= 1'b0;
            din_q     <= '0;
            inv_q     <= 1'b0;
            mdata_q   <= '0;
            mvalid_q  <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            inv_q <= 1'b0;
            if (mvalid_q && bus.m_ready) begin
                mvalid_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        din_q   <= mem_q[rptr_q[PW-1:0]];
                        inv_q   <= 1'b1;
                        timer_q <= '0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.fir_out_valid) begin
                        mdata_q  <= bus.fir_data_out;
                        mvalid_q <= 1'b1;
                        state_q  <= IDLE;
                    end else if (timer_q == T_LAST) begin
                        terr_q    <= 1'b1;
                        recover_q <= 1'b1;
                        rec_cnt_q <= 1'b0;
                        state_q   <= RECOVER;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                RECOVER: begin
                    if (rec_cnt_q) begin
                        recover_q <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        rec_cnt_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.s_ready      = ~full_q;
    assign bus.m_data       = mdata_q;
    assign bus.m_valid      = mvalid_q;
    assign bus.fir_data_in  = din_q;
    assign bus.fir_in_valid = inv_q;
    assign bus.fir_srst_n   = ~(rst | recover_q);
    assign bus.timeout_err  = terr_q;
    assign bus.overrun_cnt  = ovr_q;
endmodule

// File: tb/tb_fir_sample_scheduler.sv
// Bench for fir_sample_scheduler: a 211-tap engine model, a queue-based
// reference of the scheduler, directed scenarios and a random phase.
module tb_fir_sample_scheduler;
    localparam int IN_W    = 16;
    localparam int ACC_W   = 40;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 512;
    localparam int NTAP    = 211;
    localparam int OVR_MAX = 65535;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fir_sample_scheduler_if bus ();

    fir_sample_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int iss_cnt = 0;
    bit eng_hang = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.fir_in_valid === 1'b1) iss_cnt++;

    function automatic int coef(input int k);
        return ((k * 7) % 13) - 6;
    endfunction

    // Newest sample at index 0.
    function automatic longint fir_of(input int h[$]);
        longint acc = 0;
        for (int k = 0; k < h.size() && k < NTAP; k++)
            acc += longint'(coef(k)) * longint'(h[k]);
        return acc;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    // Engine: result appears 424 edges after the edge that raised data_in_valid.
    int     ehist[$];
    int     e_cnt = 0;
    bit     e_pend = 1'b0;
    longint e_res = 0;
    always @(posedge clk or negedge bus.fir_srst_n) begin
        if (!bus.fir_srst_n) begin
            ehist.delete();
            e_pend = 1'b0;
            bus.fir_out_valid <= 1'b0;
            bus.fir_data_out  <= '0;
        end else begin
            bus.fir_out_valid <= 1'b0;
            if (e_pend) begin
                e_cnt--;
                if (e_cnt == 0) begin
                    e_pend = 1'b0;
                    if (!eng_hang) begin
                        bus.fir_out_valid <= 1'b1;
                        bus.fir_data_out  <= ACC_W'(e_res);
                    end
                end
            end
            if (bus.fir_in_valid) begin
                ehist.push_front(int'($signed(bus.fir_data_in)));
                if (ehist.size() > NTAP) void'(ehist.pop_back());
                e_res  = fir_of(ehist);
                e_cnt  = 423;
                e_pend = 1'b1;
            end
        end
    end

    // Reference model of the scheduler.
    int     mq[$];
    int     hist[$];
    bit     m_sready = 1'b1;
    bit     m_mvalid = 1'b0;
    longint m_mdata = 0;
    bit     m_inv = 1'b0;
    int     m_din = 0;
    bit     m_terr = 1'b0;
    int     m_ovr = 0;
    bit     waiting = 1'b0;
    int     rec_left = 0;
    int     mcyc = 0;
    int     t_issue = 0;
    bit     pre_mvalid;
    bit     pre_sready;
    int     pre_size;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            hist.delete();
            m_sready = 1'b1;
            m_mvalid = 1'b0;
            m_mdata  = 0;
            m_inv    = 1'b0;
            m_din    = 0;
            m_terr   = 1'b0;
            m_ovr    = 0;
            waiting  = 1'b0;
            rec_left = 0;
            mcyc     = 0;
        end else begin
            pre_mvalid = m_mvalid;
            pre_sready = m_sready;
            pre_size   = mq.size();
            mcyc++;
            if (bus.s_valid && !pre_sready && m_ovr != OVR_MAX) m_ovr++;
            if (pre_mvalid && bus.m_ready) m_mvalid = 1'b0;
            m_inv = 1'b0;
            if (rec_left > 0) begin
                rec_left--;
            end else if (waiting) begin
                if (bus.fir_out_valid) begin
                    m_mvalid = 1'b1;
                    m_mdata  = fir_of(hist);
                    waiting  = 1'b0;
                end else if (mcyc - t_issue == TIMEOUT) begin
                    m_terr   = 1'b1;
                    waiting  = 1'b0;
                    rec_left = 2;
                    hist.delete();
                end
            end else if (bus.enable && pre_size > 0 && !pre_mvalid) begin
                m_din   = mq.pop_front();
                m_inv   = 1'b1;
                waiting = 1'b1;
                t_issue = mcyc;
                hist.push_front(m_din);
                if (hist.size() > NTAP) void'(hist.pop_back());
            end
            if (bus.flush) mq.delete();
            else if (bus.s_valid && pre_sready)
                mq.push_back(int'($signed(bus.s_data)));
            m_sready = (mq.size() < DEPTH);
        end
    end

    always @(negedge clk) begin
        chk("s_ready", bus.s_ready, m_sready);
        chk("m_valid", bus.m_valid, m_mvalid);
        chk("m_data", longint'($signed(bus.m_data)), m_mdata);
        chk("fir_in_valid", bus.fir_in_valid, m_inv);
        chk("fir_data_in", longint'($signed(bus.fir_data_in)), m_din);
        chk("timeout_err", bus.timeout_err, m_terr);
        chk("overrun_cnt", bus.overrun_cnt, m_ovr);
        chk("fir_srst_n", bus.fir_srst_n, !(rst || rec_left > 0));
    end

    int e_cyc = 0;
    int base = 0;

    task automatic push(input int v);
        bus.s_valid = 1'b1;
        bus.s_data  = IN_W'(v);
        @(negedge clk);
        e_cyc = cyc;
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_mvalid(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (bus.m_valid) break;
            @(negedge clk);
        end
    endtask

    task automatic wait_terr(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (bus.timeout_err) break;
            @(negedge clk);
        end
    endtask

    initial begin
        bus.enable  = 1'b0;
        bus.flush   = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_srst_n", bus.fir_srst_n, 0);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_s_ready", bus.s_ready, 1);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_srst_n_rel", bus.fir_srst_n, 1);

        // single sample, latency and first result
        bus.enable = 1'b1;
        base = iss_cnt;
        push(100);
        chk("s1_no_issue_yet", bus.fir_in_valid, 0);
        @(negedge clk);
        chk("s1_in_valid", bus.fir_in_valid, 1);
        chk("s1_data_in", bus.fir_data_in, 100);
        wait_mvalid(1000);
        chk("s1_latency", cyc - e_cyc, 426);
        chk("s1_m_data", longint'($signed(bus.m_data)), -600);
        chk("s1_issues", iss_cnt - base, 1);

        // result held -> no further issue
        @(negedge clk);
        bus.m_ready = 1'b0;
        base = iss_cnt;
        push(11);
        push(-22);
        push(33);
        wait_mvalid(1000);
        repeat (60) @(negedge clk);
        chk("s2_one_issue", iss_cnt - base, 1);
        bus.m_ready = 1'b1;
        repeat (3 * 430) @(negedge clk);
        chk("s2_three_issues", iss_cnt - base, 3);

        // overflow while paused
        bus.enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = IN_W'($urandom);
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
        chk("s3_s_ready_low", bus.s_ready, 0);
        chk("s3_overrun", bus.overrun_cnt, 2);
        base = iss_cnt;
        bus.enable = 1'b1;
        repeat (8 * 430) @(negedge clk);
        chk("s3_eight_issues", iss_cnt - base, 8);
        chk("s3_s_ready_back", bus.s_ready, 1);

        // hung engine -> watchdog and recovery
        eng_hang = 1'b1;
        push(77);
        wait_terr(700);
        chk("s4_timeout_at", cyc - e_cyc, 513);
        chk("s4_srst_lo0", bus.fir_srst_n, 0);
        @(negedge clk);
        chk("s4_srst_lo1", bus.fir_srst_n, 0);
        @(negedge clk);
        chk("s4_srst_hi", bus.fir_srst_n, 1);
        eng_hang = 1'b0;
        push(5);
        wait_mvalid(1000);
        chk("s4_after_recover", longint'($signed(bus.m_data)), -30);
        @(negedge clk);

        // pause, resume, then flush with a colliding push
        bus.enable = 1'b0;
        base = iss_cnt;
        for (int i = 0; i < 4; i++) push(i * 1000 - 1500);
        repeat (20) @(negedge clk);
        chk("s5_paused", iss_cnt - base, 0);
        bus.enable = 1'b1;
        repeat (4 * 430) @(negedge clk);
        chk("s5_four_issues", iss_cnt - base, 4);
        bus.enable = 1'b0;
        for (int i = 0; i < 3; i++) push(i + 40);
        bus.s_valid = 1'b1;
        bus.s_data  = IN_W'(999);
        bus.flush   = 1'b1;
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.flush   = 1'b0;
        chk("s5_flush_ready", bus.s_ready, 1);
        base = iss_cnt;
        bus.enable = 1'b1;
        repeat (20) @(negedge clk);
        chk("s5_flush_no_issue", iss_cnt - base, 0);

        // reset during WAIT
        push(9);
        repeat (100) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("s6_srst_n", bus.fir_srst_n, 0);
        chk("s6_m_valid", bus.m_valid, 0);
        chk("s6_in_valid", bus.fir_in_valid, 0);
        chk("s6_s_ready", bus.s_ready, 1);
        chk("s6_terr", bus.timeout_err, 0);
        chk("s6_overrun", bus.overrun_cnt, 0);
        chk("s6_m_data", longint'($signed(bus.m_data)), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (500) @(negedge clk);
        chk("s6_no_late_result", bus.m_valid, 0);

        // random traffic
        for (int i = 0; i < 6000; i++) begin
            bus.s_valid = ($urandom_range(0, 3) == 0);
            bus.s_data  = IN_W'($urandom);
            bus.m_ready = ($urandom_range(0, 3) != 0);
            bus.enable  = ($urandom_range(0, 15) != 0);
            bus.flush   = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
        bus.flush   = 1'b0;
        bus.m_ready = 1'b1;
        bus.enable  = 1'b1;
        repeat (1000) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
